mem_arbiter: RTL and testbench

Two-port arbiter that shares the single data cache between the instruction-fetch port (read-only) and the load/store port. It sits between the core's fetch/LSU and the cache's `addr/read/write/data_in/data_out/hit` port. It holds the grant locked for the whole cache transaction, including miss, write-back and fill cycles, so the cache address never changes mid-miss. Arbitration uses fixed data-side priority, with a bounded streak so instruction fetch cannot starve.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_stall_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data cache-port arbiter.
// Optional feature macro: MEM_ARB_PERF_CNT_EN (stall-cycle counters).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  localparam int ARB_STREAK_W = 4;
  localparam int ARB_CNT_W    = 32;

  // One cache word: four bytes, byte 0 leftmost.
  typedef logic [0:3][7:0] arb_word_t;

endpackage

// File: rtl/arb_stall_counter.sv
// Saturating event counter used for per-port stall statistics.
// Only instantiated when MEM_ARB_PERF_CNT_EN is defined.
module arb_stall_counter
  import mem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 en,
  output logic [ARB_CNT_W-1:0] count
);

  logic [ARB_CNT_W-1:0] count_q;
  logic [ARB_CNT_W-1:0] count_d;

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + ARB_CNT_W'(1);
    end
  end

  // Counter register, cleared by the shared asynchronous reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one cache port between instruction fetch (read
// only) and load/store. The grant stays locked for a whole cache transaction
// (hit, miss, write-back, fill) so the cache address is stable during a miss.
// Data side has fixed priority, bounded by a streak counter so fetch cannot
// starve. Optional feature macro: MEM_ARB_PERF_CNT_EN adds the
// i_stall_cycles / d_stall_cycles outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int D_STREAK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [0:3][7:0]      i_data_out,
  output logic                 i_ready,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [0:3][7:0]      d_data_in,
  output logic [0:3][7:0]      d_data_out,
  output logic                 d_ready,
  output logic [31:0]          c_addr,
  output logic                 c_read,
  output logic                 c_write,
  output logic [0:3][7:0]      c_data_in,
  input  logic [0:3][7:0]      c_data_out,
  input  logic                 c_hit
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [ARB_CNT_W-1:0] i_stall_cycles,
  output logic [ARB_CNT_W-1:0] d_stall_cycles
`endif
);

  localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(D_STREAK_MAX);

  arb_state_t              state_q;
  arb_state_t              state_d;
  logic [ARB_STREAK_W-1:0] streak_q;
  logic [ARB_STREAK_W-1:0] streak_d;
  logic                    d_req;

  assign d_req = d_read | d_write;

  // Streak increment that holds at the configured limit.
  function automatic logic [ARB_STREAK_W-1:0] streak_inc(input logic [ARB_STREAK_W-1:0] s);
    if (s >= STREAK_MAX) begin
      streak_inc = STREAK_MAX;
    end else begin
      streak_inc = s + ARB_STREAK_W'(1);
    end
  endfunction

  // Cache-side mux and per-port ready/data, all decoded from the locked grant.
  always_comb begin
    c_addr     = '0;
    c_read     = 1'b0;
    c_write    = 1'b0;
    c_data_in  = '0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_data_out = '0;
    d_data_out = '0;
    case (state_q)
      ARB_GRANT_I: begin
        c_addr     = i_addr;
        c_read     = i_read;
        i_ready    = i_read & c_hit;
        i_data_out = c_data_out;
      end
      ARB_GRANT_D: begin
        c_addr     = d_addr;
        c_read     = d_read;
        c_write    = d_write;
        c_data_in  = d_data_in;
        d_ready    = d_req & c_hit;
        d_data_out = c_data_out;
      end
      default: ;
    endcase
  end

  // Grant selection: arbitration from idle, hand-over on completion, and
  // fall back to idle when the granted port withdraws its request.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    case (state_q)
      ARB_IDLE: begin
        if (d_req && !(i_read && (streak_q == STREAK_MAX))) begin
          state_d  = ARB_GRANT_D;
          streak_d = i_read ? streak_inc(streak_q) : '0;
        end else if (i_read) begin
          state_d  = ARB_GRANT_I;
          streak_d = '0;
        end
      end
      ARB_GRANT_I: begin
        if (!i_read) begin
          state_d = ARB_IDLE;
        end else if (i_ready) begin
          // The fetch being retired does not count as a pending I request.
          if (d_req) begin
            state_d  = ARB_GRANT_D;
            streak_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_GRANT_D: begin
        if (!d_req) begin
          state_d = ARB_IDLE;
        end else if (d_ready) begin
          if (i_read) begin
            state_d  = ARB_GRANT_I;
            streak_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Grant state and streak registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  arb_stall_counter u_i_stall (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (i_read & ~i_ready),
    .count (i_stall_cycles)
  );

  arb_stall_counter u_d_stall (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (d_req & ~d_ready),
    .count (d_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural direct-mapped cache model
// (16-byte lines, 256 sets, hit same cycle, clean miss 6 grant cycles before
// hit, dirty miss 11). Optional macro: MEM_ARB_PERF_CNT_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        rst_b;
  logic [31:0] i_addr;
  logic        i_read;
  arb_word_t   i_data_out;
  logic        i_ready;
  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  arb_word_t   d_data_in;
  arb_word_t   d_data_out;
  logic        d_ready;
  logic [31:0] c_addr;
  logic        c_read;
  logic        c_write;
  arb_word_t   c_data_in;
  arb_word_t   c_data_out;
  logic        c_hit;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [ARB_CNT_W-1:0] i_stall_cycles;
  logic [ARB_CNT_W-1:0] d_stall_cycles;
`endif

  mem_arbiter #(.D_STREAK_MAX(4)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_addr     (i_addr),
    .i_read     (i_read),
    .i_data_out (i_data_out),
    .i_ready    (i_ready),
    .d_addr     (d_addr),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_data_in  (d_data_in),
    .d_data_out (d_data_out),
    .d_ready    (d_ready),
    .c_addr     (c_addr),
    .c_read     (c_read),
    .c_write    (c_write),
    .c_data_in  (c_data_in),
    .c_data_out (c_data_out),
    .c_hit      (c_hit)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .i_stall_cycles (i_stall_cycles),
    .d_stall_cycles (d_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- cache model ----------------
  bit [31:0]  mem   [0:8191];
  bit [19:0]  ctag  [0:255];
  bit [255:0] cvalid;
  bit [255:0] cdirty;
  int         mcnt;
  logic [7:0] cidx;
  logic       creq;
  logic       line_hit;
  logic       line_dirty;

  always_comb begin
    cidx       = c_addr[11:4];
    creq       = c_read | c_write;
    line_hit   = cvalid[cidx] && (ctag[cidx] == c_addr[31:12]);
    line_dirty = cvalid[cidx] && cdirty[cidx];
    c_hit      = creq && (line_hit || (mcnt == (line_dirty ? 11 : 6)));
    c_data_out = mem[c_addr[14:2]];
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mcnt   <= 0;
      cvalid <= '0;
      cdirty <= '0;
    end else begin
      if (creq && !c_hit) mcnt <= mcnt + 1;
      else                mcnt <= 0;
      if (creq && c_hit) begin
        cvalid[cidx] <= 1'b1;
        ctag[cidx]   <= c_addr[31:12];
        if (!line_hit) cdirty[cidx] <= 1'b0;
        if (c_write) begin
          cdirty[cidx]        <= 1'b1;
          mem[c_addr[14:2]]   <= c_data_in;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    arb_word_t   dd;
    logic [31:0] e_caddr;
    logic        e_crd;
    logic        e_cwr;
    logic        e_ir;
    logic        e_dr;
    arb_word_t   e_id;
    arb_word_t   e_dd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input arb_word_t dd,
                              input logic [31:0] ea, input logic erd, input logic ewr,
                              input logic eir, input logic edr, input arb_word_t eid,
                              input arb_word_t edd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.e_caddr = ea; v.e_crd = erd; v.e_cwr = ewr; v.e_ir = eir; v.e_dr = edr;
    v.e_id = eid; v.e_dd = edd;
    return v;
  endfunction

  localparam int NV = 20;
  localparam arb_word_t W0 = '0;
  localparam arb_word_t WA = {8'd11, 8'd22, 8'd33, 8'd44};
  localparam arb_word_t WB = {8'd1, 8'd2, 8'd3, 8'd4};

  vec_t        vt [NV];
  logic [31:0] st_exp [11];
  int          lat;
  arb_word_t   got_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cold read 0x100, same-port store with idle bubble, store->fetch
    // hand-over, then both ports held continuously (D/I alternation).
    vt[0] = mk(0, 0, 1, 0, 32'h100, W0, 32'h0, 0, 0, 0, 0, W0, W0);
    for (int i = 1; i < 7; i++)
      vt[i] = mk(0, 0, 1, 0, 32'h100, W0, 32'h100, 1, 0, 0, 0, W0, W0);
    vt[7]  = mk(0, 0, 1, 0, 32'h100, W0, 32'h100, 1, 0, 0, 1, W0, W0);
    vt[8]  = mk(0, 0, 0, 1, 32'h100, WA, 32'h0, 0, 0, 0, 0, W0, W0);
    vt[9]  = mk(1, 32'h100, 0, 1, 32'h100, WA, 32'h100, 0, 1, 0, 1, W0, W0);
    vt[10] = mk(1, 32'h100, 0, 0, 32'h0, W0, 32'h100, 1, 0, 1, 0, WA, W0);
    vt[11] = mk(0, 0, 0, 0, 32'h0, W0, 32'h0, 0, 0, 0, 0, W0, W0);
    vt[12] = mk(0, 0, 0, 1, 32'h104, WB, 32'h0, 0, 0, 0, 0, W0, W0);
    vt[13] = mk(0, 0, 0, 1, 32'h104, WB, 32'h104, 0, 1, 0, 1, W0, W0);
    vt[14] = mk(1, 32'h100, 1, 0, 32'h104, W0, 32'h0, 0, 0, 0, 0, W0, W0);
    vt[15] = mk(1, 32'h100, 1, 0, 32'h104, W0, 32'h104, 1, 0, 0, 1, W0, WB);
    vt[16] = mk(1, 32'h100, 1, 0, 32'h104, W0, 32'h100, 1, 0, 1, 0, WA, W0);
    vt[17] = mk(1, 32'h100, 1, 0, 32'h104, W0, 32'h104, 1, 0, 0, 1, W0, WB);
    vt[18] = mk(1, 32'h100, 0, 0, 32'h104, W0, 32'h100, 1, 0, 1, 0, WA, W0);
    vt[19] = mk(0, 0, 0, 0, 32'h0, W0, 32'h0, 0, 0, 0, 0, W0, W0);

    st_exp = '{32'h0, 32'h300, 32'h0, 32'h300, 32'h0, 32'h300, 32'h0, 32'h300,
               32'h0, 32'h100, 32'h300};

    // Reset with a fetch request already raised: outputs must stay quiet.
    rst_b = 1'b1; i_read = 1'b1; i_addr = 32'h55; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_data_in = '0;
    #2 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {c_addr, c_read, c_write, c_data_in, i_ready, d_ready,
                            i_data_out, d_data_out}, '0);
    i_read = 1'b0; i_addr = '0;
    rst_b = 1'b1;

    // Table-driven vectors, one clock each.
    for (int i = 0; i < NV; i++) begin
      i_read = vt[i].ir; i_addr = vt[i].ia; d_read = vt[i].dr; d_write = vt[i].dw;
      d_addr = vt[i].da; d_data_in = vt[i].dd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {c_addr, c_read, c_write, i_ready, d_ready, i_data_out, d_data_out},
            {vt[i].e_caddr, vt[i].e_crd, vt[i].e_cwr, vt[i].e_ir, vt[i].e_dr,
             vt[i].e_id, vt[i].e_dd});
`ifdef MEM_ARB_PERF_CNT_EN
      if (i == 8)  check("d_stall_cold", d_stall_cycles, 7);
      if (i == 11) check("d_stall_hit", d_stall_cycles, 8);
`endif
      @(posedge clk); #1;
    end

    // Dirty miss on D to 0x1100; fetch to 0x200 raised mid-miss must wait.
    for (int k = 0; k < 15; k++) begin
      d_read = (k <= 12); d_write = 1'b0; d_addr = 32'h1100;
      i_read = (k >= 4);  i_addr = 32'h200;
      @(negedge clk);
      if (k == 0)
        check("dmiss_k0", {c_addr, c_read, i_ready, d_ready}, {32'h0, 3'b000});
      else if (k <= 12)
        check($sformatf("dmiss_k%0d", k), {c_addr, c_read, i_ready, d_ready},
              {32'h1100, 1'b1, 1'b0, (k == 12)});
      else
        check($sformatf("dmiss_k%0d", k), {c_addr, c_read, i_ready, d_ready},
              {32'h200, 3'b100});
      @(posedge clk); #1;
    end

    // Reset pulsed during the fetch fill: outputs clear without a clock edge.
    #2 rst_b = 1'b0;
    #1;
    check("async_reset_mid_fill", {c_addr, c_read, c_write, c_data_in, i_ready,
                                   d_ready, i_data_out, d_data_out}, '0);
`ifdef MEM_ARB_PERF_CNT_EN
    check("stall_cnt_reset", {i_stall_cycles, d_stall_cycles}, '0);
`endif
    @(posedge clk); #1;
    i_read = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Fresh fetch after reset is a cold (clean) miss: ready 7 cycles later.
    i_read = 1'b1; i_addr = 32'h100;
    lat = -1;
    got_data = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (i_ready) begin
        lat = n;
        got_data = i_data_out;
        break;
      end
      @(posedge clk); #1;
    end
    check("cold_i_latency", lat, 7);
    check("cold_i_data", got_data, WA);
    @(posedge clk); #1;

    // Streak limit: fetch held, D repeatedly granted then withdrawn; the
    // fifth contention goes to I, which then hands straight back to D.
    for (int k = 0; k < 11; k++) begin
      i_read = (k <= 9); i_addr = 32'h100;
      d_read = (k <= 8) ? ((k % 2) == 0) : (k == 9);
      d_write = 1'b0; d_addr = 32'h300;
      @(negedge clk);
      check($sformatf("streak_k%0d", k), {c_addr, i_ready}, {st_exp[k], (k == 9)});
      @(posedge clk); #1;
    end
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);
    check("final_idle", {c_addr, c_read, c_write, i_ready, d_ready}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
